// File: rtl/dsi_tx_line_reader_if.sv
// Bundle of FIFO read-side, line control and byte-stream signals for the DSI TX line reader.
// master = the line reader itself, slave = the FIFO / packet assembler environment.
interface dsi_tx_line_reader_if;
  logic [31:0] fifo_data;
  logic        fifo_not_empty;
  logic        fifo_line_ready;
  logic        fifo_read_ack;
  logic        line_start;
  logic        line_busy;
  logic        line_done;
  logic [7:0]  pixel_byte;
  logic        pixel_byte_valid;
  logic        pixel_byte_ready;
  logic        pixel_byte_last;
  logic [15:0] crc_out;
  logic        crc_valid;
  logic        underflow;

  modport master (
    input  fifo_data, fifo_not_empty, fifo_line_ready, line_start, pixel_byte_ready,
    output fifo_read_ack, line_busy, line_done, pixel_byte, pixel_byte_valid,
           pixel_byte_last, crc_out, crc_valid, underflow
  );

  modport slave (
    output fifo_data, fifo_not_empty, fifo_line_ready, line_start, pixel_byte_ready,
    input  fifo_read_ack, line_busy, line_done, pixel_byte, pixel_byte_valid,
           pixel_byte_last, crc_out, crc_valid, underflow
  );
endinterface

// File: rtl/dsi_tx_line_reader.sv
// Pops 32-bit words from the show-ahead pixel FIFO and serialises one line as a byte stream.
// Optional payload CRC-16 (reflected 0x8408) enabled by defining DSI_TX_LINE_READER_CRC_EN.
module dsi_tx_line_reader #(
  parameter int LINE_BYTES = 640,
  parameter int CNT_W      = $clog2(LINE_BYTES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dsi_tx_line_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, STREAM, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             underflow_q, underflow_d;
  logic             is_last;
  logic             handshake;
  logic [7:0]       byte_sel;

  assign is_last  = (cnt_q == CNT_W'(LINE_BYTES - 1));
  assign byte_sel = bus.fifo_data[{idx_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    idx_d                = idx_q;
    underflow_d          = underflow_q;
    handshake            = 1'b0;
    bus.pixel_byte       = 8'h00;
    bus.pixel_byte_valid = 1'b0;
    bus.pixel_byte_last  = 1'b0;
    bus.fifo_read_ack    = 1'b0;
    bus.line_done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.line_start) begin
          state_d     = WAIT_LINE;
          cnt_d       = '0;
          idx_d       = '0;
          underflow_d = 1'b0;
        end
      end
      WAIT_LINE: begin
        if (bus.fifo_line_ready) state_d = STREAM;
      end
      STREAM: begin
        bus.pixel_byte       = byte_sel;
        bus.pixel_byte_valid = bus.fifo_not_empty;
        bus.pixel_byte_last  = is_last;
        if (!bus.fifo_not_empty) underflow_d = 1'b1;
        handshake = bus.fifo_not_empty & bus.pixel_byte_ready;
        if (handshake) begin
          // The final word is popped even when its upper lanes are unused.
          bus.fifo_read_ack = (idx_q == 2'd3) | is_last;
          idx_d             = idx_q + 2'd1;
          if (is_last) state_d = FINISH;
          else         cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      FINISH: begin
        bus.line_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.line_busy = (state_q != IDLE);
  assign bus.underflow = underflow_q;

`ifdef DSI_TX_LINE_READER_CRC_EN
  logic [15:0]      crc_q, crc_d;
  logic [8:0][15:0] crc_chain;
  logic             crc_init;

  assign crc_init     = (state_q == IDLE) & bus.line_start;
  assign crc_chain[0] = crc_q;

  // One reflected CCITT step per payload bit, LSB first.
  for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
    assign crc_chain[gi+1] = (crc_chain[gi][0] ^ byte_sel[gi])
                           ? ((crc_chain[gi] >> 1) ^ 16'h8408)
                           : (crc_chain[gi] >> 1);
  end

  always_comb begin
    crc_d = crc_q;
    if (crc_init)       crc_d = 16'hFFFF;
    else if (handshake) crc_d = crc_chain[8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 16'h0000;
    else        crc_q <= crc_d;
  end

  assign bus.crc_out   = crc_q;
  assign bus.crc_valid = (state_q == FINISH);
`else
  assign bus.crc_out   = 16'h0000;
  assign bus.crc_valid = 1'b0;
`endif

endmodule

// File: doc/dsi_tx_line_reader.md
# dsi_tx_line_reader

Reader-side consumer of the DSI TX pixel FIFO. Waits for a full line to be buffered, pops 32-bit pixel words from the show-ahead FIFO and serialises them into a byte stream for the long-packet assembler. Optionally computes the DSI payload CRC-16 for the line. Runs entirely in the PHY clock domain, on the FIFO read side.

## Interface
- `LINE_BYTES`, 640: payload bytes per line; range 1..65535; need not be a multiple of 4.
- `CNT_W`, `$clog2(LINE_BYTES+1)`: width of the byte counter.

Ports:
- `clk`  in  1  clock; same clock as the FIFO read side.
- `rst_n`  in  1  asynchronous reset, active low.
- `fifo_data`  in  32  show-ahead FIFO head word; byte 0 is `[7:0]`.
- `fifo_not_empty`  in  1  FIFO head word is valid.
- `fifo_line_ready`  in  1  at least one line is buffered.
- `fifo_read_ack`  out  1  pops the head word; combinational.
- `line_start`  in  1  single-cycle request to stream one line.
- `line_busy`  out  1  high from accepted `line_start` until `line_done`.
- `line_done`  out  1  single-cycle pulse at end of line.
- `pixel_byte`  out  8  payload byte.
- `pixel_byte_valid`  out  1  byte valid.
- `pixel_byte_ready`  in  1  downstream accepts.
- `pixel_byte_last`  out  1  marks byte `LINE_BYTES-1`.
- `crc_out`  out  16  payload CRC.
- `crc_valid`  out  1  single-cycle pulse when `crc_out` is valid.
- `underflow`  out  1  sticky flag: FIFO ran empty mid-line.

## Operation
- **FSM states:** IDLE, WAIT_LINE, STREAM, FINISH.
- **IDLE:**
  - `line_start` → WAIT_LINE; byte counter cleared; CRC register set to 16'hFFFF.
  - `line_start` in any other state is ignored.
- **WAIT_LINE:** `fifo_line_ready` → STREAM.
- **STREAM:**
  - `pixel_byte = fifo_data[8*byte_idx +: 8]`, where `byte_idx` (2 bits) is the byte lane within the word.
  - `pixel_byte_valid = fifo_not_empty`.
  - On handshake (`valid & ready`): `byte_idx` and the byte counter increment, and the CRC is updated.
  - `fifo_read_ack = handshake & (byte_idx==3 | last byte)`. On the last byte, the final word is popped even if it is only partially used; its unused upper bytes are discarded.
  - After the last-byte handshake → FINISH.
- **Underflow:** if `fifo_not_empty` is low in STREAM, `pixel_byte_valid` is 0 and `underflow` is set.
  - `underflow` is cleared only by reset or by the next accepted `line_start`.
  - Streaming resumes when the FIFO refills.
- **FINISH:** lasts one cycle. `line_done` = 1 and `crc_valid` = 1 (CRC build only). Then → IDLE.
- **Counter arithmetic:**
  - The byte counter is `CNT_W` bits, compared against `LINE_BYTES-1`, and never wraps.
  - `byte_idx` wraps 3 → 0.
- **CRC:** CRC-16/CCITT, polynomial 0x1021 applied reflected (0x8408).
  - Init 0xFFFF, LSB-first, no final XOR.
  - Processed one byte per handshake, with 8 bit-iterations unrolled combinationally.

## Timing
- Reset values: `fifo_read_ack` 0, `line_busy` 0, `line_done` 0, `pixel_byte` 8'h00, `pixel_byte_valid` 0, `pixel_byte_last` 0, `crc_out` 16'h0000, `crc_valid` 0, `underflow` 0; FSM in IDLE.
- `line_start` → WAIT_LINE on the next edge.
- WAIT_LINE with `fifo_line_ready` = 1 → STREAM one cycle later.
- Best case: first `pixel_byte_valid` 2 cycles after `line_start`.
- Throughput is 1 byte/cycle while ready and not empty. `pixel_byte`, `pixel_byte_valid` and `pixel_byte_last` are driven combinationally from the state and FIFO head.
- Valid is held until ready; a byte never changes while valid and not accepted.
- `line_done` and `crc_valid` occur the cycle after the last-byte handshake. `crc_out` holds its value until the next `line_start`.
- An async reset mid-line returns everything to reset values immediately. Bytes already popped are lost; the FIFO is not flushed by this block.

## Configuration
- Macro `DSI_TX_LINE_READER_CRC_EN`.
- **Defined:** CRC logic is present; `crc_out` and `crc_valid` behave as above.
- **Undefined:** no CRC logic; `crc_out` is tied to 16'h0000 and `crc_valid` to 0. `line_done` timing is unchanged.

## Test plan
- **Basic line:** `LINE_BYTES`=8; FIFO holds 0x44332211, 0x88776655; `ready` tied 1 → bytes 11,22,…,88 on consecutive cycles; ack pulses on bytes 4 and 8; `last` on 88; `line_done` 1 cycle later.
- **CRC vector:** `LINE_BYTES`=9; words 0x34333231, 0x38373635, 0x00000039 ("123456789") → `crc_out`=0x6F91 with `crc_valid` pulse; exactly 3 acks. Macro undefined → `crc_out`=0x0000, `crc_valid` never asserts.
- **Backpressure:** `ready` toggled 1010… → every byte held stable while valid and not ready; no duplicated or skipped bytes; acks only on accepted lane-3 bytes.
- **Wait/underflow:** `line_start` with `fifo_line_ready`=0 for 20 cycles → no valid, `line_busy`=1. Then `fifo_not_empty` dropped for 5 cycles mid-line → valid low and `underflow`=1. The line completes after refill, and `underflow` clears on the next `line_start`.
- **Ignored start / reset:** `line_start` during STREAM → no effect, byte count unchanged. `rst_n` low mid-line → all outputs return to reset values; a new line after reset streams correctly.
